bus_arbiter: RTL and testbench
==============================

Name: bus_arbiter

Overview:
- Two-master arbiter and sequencer in front of the system address decoder.
- Shares the single decoder bus (RAM plus memory-mapped LEDs/keyboard) between master 0 (core load/store unit) and master 1 (debug/DMA port).
- Latches the winning request, drives the bus for a fixed number of cycles chosen by address region, then returns read data with a one-cycle ready pulse.
- Round-robin on simultaneous requests; one transaction in flight.

Parameters:
RAM_SIZE, 256, byte size of RAM region; addresses 0..RAM_SIZE-1 are RAM
RAM_LATENCY, 2, bus cycles a RAM access occupies (legal range 1..15)

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
m0_req  in  1  master 0 transaction request
m0_we  in  1  master 0 write enable
m0_addr  in  32  master 0 address
m0_wdata  in  32  master 0 write data
m0_rdata  out  32  master 0 read data, valid while m0_ready=1
m0_ready  out  1  master 0 completion pulse
m1_req  in  1  master 1 transaction request
m1_we  in  1  master 1 write enable
m1_addr  in  32  master 1 address
m1_wdata  in  32  master 1 write data
m1_rdata  out  32  master 1 read data, valid while m1_ready=1
m1_ready  out  1  master 1 completion pulse
bus_require  out  1  to decoder require
bus_write_enable  out  1  to decoder write_enable
bus_address  out  32  to decoder address
bus_wdata  out  32  write data to RAM/peripherals
bus_rdata  in  32  decoder out_data

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Registers: state (IDLE, BUSY, DONE), grant (0/1), last_grant, cnt[3:0], latched we/addr/wdata, rdata.
- Reset values:
  - state=IDLE, last_grant=1 (master 0 wins the first tie).
  - All outputs 0: bus_require, bus_write_enable, bus_address, bus_wdata, m*_ready, m*_rdata.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that master.
  - Both req: grant the master that is not last_grant.
  - On grant, latch that master's we/addr/wdata and load cnt with L-1, where L=RAM_LATENCY if addr<RAM_SIZE (unsigned compare), else L=1. Go to BUSY.
- BUSY:
  - Outputs: bus_require=1, bus_write_enable=latched we, bus_address/bus_wdata=latched values.
  - cnt>0: decrement.
  - cnt==0: capture bus_rdata into rdata and set last_grant=grant. Go to DONE.
- DONE:
  - Bus outputs: bus_require=0, bus_write_enable=0.
  - Granted master's ready=1 for exactly this cycle; that master's rdata holds the captured value. For writes, rdata also holds the captured bus_rdata.
  - Always go to IDLE next; no grant is made in DONE.
- Bus outputs outside BUSY: bus_require=0 and bus_write_enable=0. bus_address/bus_wdata hold their last values.
- m*_rdata holds its value until that master's next DONE.
- Timing: request sampled high in cycle n.
  - Bus active in cycles n+1..n+L.
  - Ready in cycle n+L+1.
  - Earliest next grant in cycle n+L+2.
- Peripheral accesses (L=1) assert bus_require for exactly one cycle. This keeps keyboard-read acknowledge a single pulse per read.
- Masters change addr/we/wdata freely after grant, because values are latched.
- A master still holding req in the DONE cycle is seen again in IDLE as a new request. Under round-robin the other master wins if both request.
- A req that drops while the master is waiting (not yet granted) is simply not served.
- Reset asserted during BUSY/DONE:
  - Abort the transaction and go to IDLE next cycle.
  - No ready pulse; bus_require=0 in the cycle after reset is sampled.
  - last_grant=1.
- m0_ready and m1_ready are never high in the same cycle.

Test Plan:
1. Reset then idle: all outputs 0 for 5 cycles with no req.
2. m0 read of addr 0x10 (RAM, RAM_LATENCY=2), bus_rdata=0xDEADBEEF:
   - bus_require high 2 cycles with bus_address=0x10, bus_write_enable=0.
   - m0_ready single pulse in the 3rd cycle after the req cycle; m0_rdata=0xDEADBEEF.
3. m1 write addr 0x80000009 data 0x5A:
   - bus_require and bus_write_enable high exactly 1 cycle, bus_wdata=0x5A.
   - m1_ready pulse in the next cycle.
4. Both masters request continuously after reset:
   - Grants alternate m0, m1, m0, m1.
   - Each master completes one transaction per 2L+4 cycles of the pair's alternation; no cycle has both ready pulses.
5. Keyboard read at 0x80003000 with bus_rdata=0x41 → exactly one cycle of bus_require, m0_rdata=0x00000041.
6. Reset asserted during the 2nd BUSY cycle of a RAM read:
   - No m0_ready pulse; bus_require=0 the next cycle.
   - Afterwards a simultaneous m0/m1 request grants m0 first.

Source files
------------

// File: rtl/bus_arbiter.sv
// Two-master round-robin arbiter that sequences one transaction at a time onto the
// shared address-decoder bus. The bus is held for a region-dependent number of cycles.
module bus_arbiter #(
  parameter int RAM_SIZE    = 256,
  parameter int RAM_LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_ready,
  input  logic        m1_req,
  input  logic        m1_we,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m1_wdata,
  output logic [31:0] m1_rdata,
  output logic        m1_ready,
  output logic        bus_require,
  output logic        bus_write_enable,
  output logic [31:0] bus_address,
  output logic [31:0] bus_wdata,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [31:0] RAM_LIMIT = 32'(RAM_SIZE);
  localparam logic [3:0]  RAM_CNT   = 4'(RAM_LATENCY - 1);

  state_t      state, next_state;
  logic        grant, last_grant;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] addr_q, wdata_q;

  logic        sel;
  logic        sel_we;
  logic [31:0] sel_addr, sel_wdata;
  logic [3:0]  sel_cnt;

  // Winner selection: a lone requester wins outright; on a tie the master that
  // did not finish the previous transaction goes first.
  always_comb begin
    sel = m1_req;
    if (m0_req && m1_req) sel = ~last_grant;
    sel_we    = sel ? m1_we    : m0_we;
    sel_addr  = sel ? m1_addr  : m0_addr;
    sel_wdata = sel ? m1_wdata : m0_wdata;
    sel_cnt   = (sel_addr < RAM_LIMIT) ? RAM_CNT : 4'd0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  // NOTE: defaulting next_state before the case keeps every path assigned, so
  // no latch is inferred when a branch leaves it untouched.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (m0_req || m1_req) next_state = BUSY;
      BUSY:    if (cnt == 4'd0)      next_state = DONE;
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      cnt        <= 4'd0;
      we_q       <= 1'b0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      m0_rdata   <= 32'd0;
      m1_rdata   <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          if (m0_req || m1_req) begin
            grant   <= sel;
            we_q    <= sel_we;
            addr_q  <= sel_addr;
            wdata_q <= sel_wdata;
            cnt     <= sel_cnt;
          end
        end
        BUSY: begin
          if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
          end else begin
            // Writes capture bus_rdata as well, so a master's rdata always
            // reflects its most recent completed access.
            if (grant) m1_rdata <= bus_rdata;
            else       m0_rdata <= bus_rdata;
            last_grant <= grant;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bus_require      = (state == BUSY);
    bus_write_enable = (state == BUSY) && we_q;
    m0_ready         = (state == DONE) && !grant;
    m1_ready         = (state == DONE) && grant;
  end

  assign bus_address = addr_q;
  assign bus_wdata   = wdata_q;

endmodule

// File: tb/tb_bus_arbiter.sv
// Bench for bus_arbiter: directed scenarios plus randomized traffic checked against
// a transaction-schedule model (grant cycle, bus window, ready cycle, free cycle).
module tb_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m0_we, m1_req, m1_we;
  logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_ready, m1_ready;
  logic        bus_require, bus_write_enable;
  logic [31:0] bus_address, bus_wdata, bus_rdata;

  int errors = 0;
  int checks = 0;

  bus_arbiter #(.RAM_SIZE(256), .RAM_LATENCY(2)) dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
    .m0_rdata(m0_rdata), .m0_ready(m0_ready),
    .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
    .m1_rdata(m1_rdata), .m1_ready(m1_ready),
    .bus_require(bus_require), .bus_write_enable(bus_write_enable),
    .bus_address(bus_address), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  // Transaction-level model: the cycle numbers at which the current transaction
  // occupies the bus, pulses ready, and frees the arbiter.
  int          cyc = 0;
  int          free_at = 0, busy_start = -10, busy_end = -10, ready_cyc = -10;
  bit          win = 1'b0, last_m = 1'b1, we_m = 1'b0;
  logic [31:0] addr_m = '0, wdata_m = '0;
  logic [31:0] rd_m [2] = '{32'd0, 32'd0};

  function automatic bit exp_busy();
    return (cyc >= busy_start) && (cyc <= busy_end);
  endfunction

  function automatic logic [1:0] exp_ready();
    return (cyc == ready_cyc) ? (win ? 2'b01 : 2'b10) : 2'b00;
  endfunction

  // Advance one clock; the model consumes the inputs driven in the ending cycle.
  task automatic tick();
    int lat;
    if (reset) begin
      free_at = cyc + 1; busy_start = -10; busy_end = -10; ready_cyc = -10;
      last_m = 1'b1; we_m = 1'b0; addr_m = '0; wdata_m = '0;
      rd_m[0] = '0; rd_m[1] = '0;
    end else begin
      if (cyc == busy_end) begin
        rd_m[win] = bus_rdata;
        last_m = win;
      end
      if (cyc >= free_at && (m0_req || m1_req)) begin
        win     = (m0_req && m1_req) ? !last_m : m1_req;
        addr_m  = win ? m1_addr : m0_addr;
        wdata_m = win ? m1_wdata : m0_wdata;
        we_m    = win ? m1_we : m0_we;
        lat     = (addr_m < 32'd256) ? 2 : 1;
        busy_start = cyc + 1;
        busy_end   = cyc + lat;
        ready_cyc  = cyc + lat + 1;
        free_at    = cyc + lat + 2;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic idle_inputs();
    m0_req = 0; m0_we = 0; m0_addr = '0; m0_wdata = '0;
    m1_req = 0; m1_we = 0; m1_addr = '0; m1_wdata = '0;
  endtask

  task automatic test_reset();
    reset = 1; idle_inputs(); bus_rdata = '0;
    tick(); tick();
    reset = 0;
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus_require, bus_write_enable, bus_address, bus_wdata, m0_ready, m1_ready,
           m0_rdata, m1_rdata} !== '0) begin
        errors++;
        $display("FAIL reset_idle cycle %0d: req=%b we=%b addr=%h wdata=%h rdy=%b%b rd0=%h rd1=%h, want all zero",
                 i, bus_require, bus_write_enable, bus_address, bus_wdata, m0_ready, m1_ready,
                 m0_rdata, m1_rdata);
      end
      tick();
    end
  endtask

  task automatic test_ram_read();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; bus_rdata = 32'hDEADBEEF;
    tick();
    idle_inputs();
    for (int i = 1; i <= 5; i++) begin
      checks++;
      if (bus_require !== (i <= 2) || (i <= 2 && (bus_address !== 32'h10 || bus_write_enable !== 1'b0))) begin
        errors++;
        $display("FAIL ram_read_bus offset %0d: req=%b we=%b addr=%h, want req=%b we=0 addr=00000010",
                 i, bus_require, bus_write_enable, bus_address, (i <= 2));
      end
      checks++;
      if ({m0_ready, m1_ready} !== {(i == 3), 1'b0}) begin
        errors++;
        $display("FAIL ram_read_ready offset %0d: m0_ready=%b m1_ready=%b, want %b 0", i, m0_ready, m1_ready, (i == 3));
      end
      if (i == 3) begin
        checks++;
        if (m0_rdata !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL ram_read_data: m0_rdata=%h want deadbeef", m0_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_periph_write();
    m1_req = 1; m1_we = 1; m1_addr = 32'h80000009; m1_wdata = 32'h5A; bus_rdata = 32'h12345678;
    tick();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      checks++;
      if ({bus_require, bus_write_enable} !== {2{i == 1}} || (i == 1 && bus_wdata !== 32'h5A)) begin
        errors++;
        $display("FAIL periph_write_bus offset %0d: req=%b we=%b wdata=%h, want req=we=%b wdata=0000005a",
                 i, bus_require, bus_write_enable, bus_wdata, (i == 1));
      end
      checks++;
      if ({m0_ready, m1_ready} !== {1'b0, (i == 2)}) begin
        errors++;
        $display("FAIL periph_write_ready offset %0d: m0_ready=%b m1_ready=%b, want 0 %b", i, m0_ready, m1_ready, (i == 2));
      end
      if (i == 2) begin
        checks++;
        if (m1_rdata !== 32'h12345678) begin
          errors++;
          $display("FAIL periph_write_rdata: m1_rdata=%h want 12345678", m1_rdata);
        end
      end
      tick();
    end
  endtask

  task automatic test_round_robin();
    reset = 1; tick(); reset = 0;
    m0_req = 1; m0_addr = 32'h20; m1_req = 1; m1_addr = 32'h44; bus_rdata = 32'h0BAD0BAD;
    for (int i = 0; i < 18; i++) begin
      checks++;
      if ({m0_ready, m1_ready} !== {(i == 3 || i == 11), (i == 7 || i == 15)}) begin
        errors++;
        $display("FAIL round_robin_ready offset %0d: m0_ready=%b m1_ready=%b, want %b %b",
                 i, m0_ready, m1_ready, (i == 3 || i == 11), (i == 7 || i == 15));
      end
      if (bus_require) begin
        checks++;
        if (bus_address !== (((i % 8) < 4) ? 32'h20 : 32'h44)) begin
          errors++;
          $display("FAIL round_robin_addr offset %0d: bus_address=%h want %h",
                   i, bus_address, (((i % 8) < 4) ? 32'h20 : 32'h44));
        end
      end
      tick();
    end
    idle_inputs();
    repeat (4) tick();
  endtask

  task automatic test_keyboard_read();
    int pulses = 0;
    m0_req = 1; m0_we = 0; m0_addr = 32'h80003000; bus_rdata = 32'h41;
    tick();
    idle_inputs();
    for (int i = 1; i <= 4; i++) begin
      if (bus_require === 1'b1) pulses++;
      if (i == 2 || i == 4) begin
        checks++;
        if (m0_ready !== (i == 2) || m0_rdata !== 32'h41) begin
          errors++;
          $display("FAIL keyboard_read offset %0d: m0_ready=%b m0_rdata=%h, want %b 00000041",
                   i, m0_ready, m0_rdata, (i == 2));
        end
      end
      tick();
    end
    checks++;
    if (pulses != 1) begin
      errors++;
      $display("FAIL keyboard_require_pulses: got %0d want 1", pulses);
    end
  endtask

  task automatic test_reset_abort();
    m0_req = 1; m0_we = 0; m0_addr = 32'h10; bus_rdata = 32'hCAFE0000;
    tick();
    idle_inputs();
    tick();
    reset = 1;
    checks++;
    if (bus_require !== 1'b1) begin
      errors++;
      $display("FAIL abort_busy2: bus_require=%b want 1", bus_require);
    end
    tick();
    reset = 0;
    checks++;
    if ({bus_require, m0_ready, m1_ready} !== 3'b000 || m0_rdata !== 32'd0) begin
      errors++;
      $display("FAIL abort_after_reset: req=%b m0_ready=%b m1_ready=%b m0_rdata=%h, want 0 0 0 00000000",
               bus_require, m0_ready, m1_ready, m0_rdata);
    end
    m0_req = 1; m0_addr = 32'h30; m1_req = 1; m1_addr = 32'h50;
    tick();
    idle_inputs();
    checks++;
    if (bus_require !== 1'b1 || bus_address !== 32'h30 || m0_ready !== 1'b0) begin
      errors++;
      $display("FAIL abort_regrant: req=%b addr=%h m0_ready=%b, want 1 00000030 0", bus_require, bus_address, m0_ready);
    end
    tick(); tick();
    checks++;
    if ({m0_ready, m1_ready} !== 2'b10 || m0_rdata !== 32'hCAFE0000) begin
      errors++;
      $display("FAIL abort_regrant_ready: m0_ready=%b m1_ready=%b m0_rdata=%h, want 1 0 cafe0000",
               m0_ready, m1_ready, m0_rdata);
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int i = 0; i < 600; i++) begin
      checks++;
      if ({bus_require, bus_write_enable} !== {exp_busy(), exp_busy() && we_m}
          || bus_address !== addr_m || bus_wdata !== wdata_m) begin
        errors++;
        $display("FAIL random_bus cycle %0d: req=%b we=%b addr=%h wdata=%h, want %b %b %h %h",
                 cyc, bus_require, bus_write_enable, bus_address, bus_wdata,
                 exp_busy(), exp_busy() && we_m, addr_m, wdata_m);
      end
      checks++;
      if ({m0_ready, m1_ready} !== exp_ready() || m0_rdata !== rd_m[0] || m1_rdata !== rd_m[1]) begin
        errors++;
        $display("FAIL random_ready cycle %0d: rdy=%b%b rd0=%h rd1=%h, want %b %h %h",
                 cyc, m0_ready, m1_ready, m0_rdata, m1_rdata, exp_ready(), rd_m[0], rd_m[1]);
      end
      reset     = ($urandom_range(0, 59) == 0);
      m0_req    = ($urandom_range(0, 2) != 0);
      m1_req    = ($urandom_range(0, 2) != 0);
      m0_we     = $urandom_range(0, 1);
      m1_we     = $urandom_range(0, 1);
      m0_addr   = $urandom_range(0, 1) ? 32'($urandom_range(0, 255)) : (32'h80000000 | $urandom);
      m1_addr   = $urandom_range(0, 1) ? 32'($urandom_range(0, 255)) : (32'h80000000 | $urandom);
      m0_wdata  = $urandom;
      m1_wdata  = $urandom;
      bus_rdata = $urandom;
      tick();
    end
    reset = 0;
    idle_inputs();
    repeat (4) tick();
  endtask

  always @(negedge clk) begin
    if (m0_ready === 1'b1 && m1_ready === 1'b1) begin
      checks++;
      errors++;
      $display("FAIL both_ready at cycle %0d: m0_ready=1 m1_ready=1, want at most one", cyc);
    end
  end

  initial begin
    test_reset();
    test_ram_read();
    test_periph_write();
    test_round_robin();
    test_keyboard_read();
    test_reset_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
